// File: rtl/reorder_sequencer.sv
// Round-robin sequencer sharing one byte-reorder datapath between two word
// requesters and handing each reordered word to a multi-cycle execute stage.
module reorder_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0Valid,
  input  logic [39:0] req0Data,
  input  logic        req0Swap,
  output logic        req0Ready,
  input  logic        req1Valid,
  input  logic [39:0] req1Data,
  input  logic        req1Swap,
  output logic        req1Ready,
  output logic [39:0] reorderDataIn,
  output logic        reorderEnable,
  input  logic [39:0] reorderDataOut,
  output logic        execValid,
  output logic [39:0] execData,
  output logic        execSource,
  input  logic        execReady,
  input  logic        execDone,
  output logic        execTimeout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] timer_q, timer_d;
  logic [39:0] exec_data_q, exec_data_d;
  logic        exec_source_q, exec_source_d;

  logic grant_vld;
  logic grant_idx;

  // With both requesters valid, the one not served last wins.
  always_comb begin
    grant_vld = req0Valid | req1Valid;
    if (req0Valid && req1Valid) grant_idx = ~last_grant_q;
    else                        grant_idx = req1Valid;
  end

  // NOTE: every output and next-state variable gets a default before the case,
  // so no path through this block leaves one unassigned (no inferred latch).
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    exec_data_d   = exec_data_q;
    exec_source_d = exec_source_q;
    req0Ready     = 1'b0;
    req1Ready     = 1'b0;
    reorderDataIn = '0;
    reorderEnable = 1'b0;
    execTimeout   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ready is held low while reset is asserted, even with a valid requester.
        if (grant_vld && rst_n) begin
          req0Ready     = ~grant_idx;
          req1Ready     = grant_idx;
          reorderDataIn = grant_idx ? req1Data : req0Data;
          reorderEnable = grant_idx ? req1Swap : req0Swap;
          exec_data_d   = reorderDataOut;
          exec_source_d = grant_idx;
          last_grant_d  = grant_idx;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (execReady) begin
          timer_d = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        timer_d = timer_q + 16'd1;
        if (execDone) begin
          state_d = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          execTimeout = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      timer_q       <= '0;
      exec_data_q   <= '0;
      exec_source_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      exec_data_q   <= exec_data_d;
      exec_source_q <= exec_source_d;
    end
  end

  assign execValid  = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign execData   = exec_data_q;
  assign execSource = exec_source_q;

endmodule

// File: doc/reorder_sequencer.md
# reorder_sequencer

Sequences and shares the execute-interface byte-reorder datapath between two word requesters (requester 0: fetch side, requester 1: operand side). It arbitrates round-robin and routes the granted 40-bit word and its swap flag through the external reorder datapath. It registers the result and hands it to the multi-cycle execute logic over a valid/ready handshake, then holds off new work until execute signals done or a timeout expires.

## Interface
- TIMEOUT, 64: maximum cycles spent in WAIT_DONE before abort; legal range 2..65535.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0Valid  in  1  requester 0 has a word.
- req0Data  in  40  requester 0 word.
- req0Swap  in  1  requester 0 wants byte order reversed.
- req0Ready  out  1  requester 0 word accepted this cycle.
- req1Valid / req1Data / req1Swap / req1Ready: same as requester 0.
- reorderDataIn  out  40  word driven to the reorder datapath.
- reorderEnable  out  1  reorder enable to the datapath.
- reorderDataOut  in  40  datapath result (combinational return).
- execValid  out  1  execData valid to execute logic.
- execData  out  40  registered reordered word.
- execSource  out  1  requester index of execData.
- execReady  in  1  execute logic accepts execData.
- execDone  in  1  execute logic finished the word.
- execTimeout  out  1  one-cycle pulse: execute abort.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE. Reset enters IDLE.
- Round-robin pointer lastGrant. Reset value is 1, so requester 0 wins first.
- IDLE grant: if exactly one reqNValid is high, grant it. If both are high, grant the requester other than lastGrant. If none is high, no grant.
- IDLE outputs (combinational):
  - Granted requester's reqNReady = 1; all others 0.
  - reorderDataIn = granted reqNData; reorderEnable = granted reqNSwap.
  - With no grant: reorderDataIn = 0, reorderEnable = 0.
- IDLE with a grant, at the clock edge:
  - execData ← reorderDataOut; execSource ← grant index; lastGrant ← grant index.
  - State → ISSUE.
- ISSUE:
  - execValid = 1; execData and execSource are held stable.
  - On execReady, state → WAIT_DONE and the timer is cleared to 0.
- WAIT_DONE:
  - Timer increments each cycle.
  - If execDone, state → IDLE.
  - Otherwise, if timer == TIMEOUT-1, execTimeout pulses for one cycle and state → IDLE.
- In ISSUE and WAIT_DONE: reqNReady = 0, reorderEnable = 0, reorderDataIn = 0.
- execDone is ignored outside WAIT_DONE. execReady is ignored outside ISSUE.
- Requesters must not make reqNValid depend on reqNReady. reqNReady depends combinationally on reqNValid.
- Timer is 16 bits, unsigned, and never wraps; TIMEOUT bounds it.

## Timing
- Reset values:
  - state IDLE, lastGrant 1, timer 0.
  - execData 0, execSource 0, execValid 0, execTimeout 0, busy 0.
  - reqNReady 0 during reset.
- Latency: accept at edge T (valid & ready) → execValid high from T+1.
- Minimum per-word occupancy is 3 cycles: IDLE accept, ISSUE with execReady, WAIT_DONE with execDone. A new accept is possible in the cycle after execDone.
- Simultaneous events:
  - execDone in the same cycle as timer == TIMEOUT-1: done wins, no timeout pulse.
  - Both requesters valid: strict alternation while both stay valid.
- Reset asserted mid-operation clears all state immediately. The in-flight word is dropped, with no done and no timeout reported.
- A requester whose valid drops in IDLE before acceptance loses nothing. The pointer only moves on actual acceptance.

## Test plan
- Single swap: req0Data=40'h0102030405, req0Swap=1 → req0Ready=1 at T; at T+1 execValid=1, execData=40'h0504030201, execSource=0.
- No swap: req1Data=40'hAABBCCDDEE, req1Swap=0 → execData=40'hAABBCCDDEE, execSource=1; reorderEnable=0 in the accept cycle.
- Contention: both valid continuously, execReady=1, execDone returned 1 cycle after entering WAIT_DONE → accepted sources are 0,1,0,1; only one reqNReady is high per cycle.
- Backpressure: hold execReady=0 for 5 cycles → execValid and execData stay stable, busy=1, both reqNReady=0; execReady=1 → WAIT_DONE next cycle.
- Timeout: TIMEOUT=8, execDone never asserted → execTimeout pulses exactly one cycle on the 8th WAIT_DONE cycle, then IDLE; a pending req0 is accepted the following cycle.
- Reset mid-op: assert rst_n=0 while in WAIT_DONE → execValid=0, busy=0, execTimeout=0 immediately; after release, req0 wins first despite a prior req0 grant.
